// File: rtl/inst_fetch_responder_pkg.sv
// inst_fetch_responder_pkg: AXI constants, fetch widths, queue entry and FSM state types
// shared by the instruction-fetch responder and its request queue.
package inst_fetch_responder_pkg;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B = 3'd2;
    localparam int INST_WIDTH = 32;
    localparam int FETCH_WIDTH = 2 * INST_WIDTH;
    localparam int CacheDisposeInstNumWidth = 2;

    typedef struct packed {
        logic [28:0] line;
        logic        uncache;
    } fetch_entry_t;

    typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
    typedef enum logic {R_LO, R_HI} r_state_t;

    function automatic logic [7:0] burst_len(input logic uncache);
        return uncache ? 8'd0 : 8'd1;
    endfunction
endpackage

// File: rtl/fetch_req_fifo.sv
// fetch_req_fifo: in-order request queue with separate write, AR-issue and response
// pointers; tracks total outstanding entries and entries not yet issued on AR.
module fetch_req_fifo
    import inst_fetch_responder_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         issue,
    input  logic         pop,
    input  fetch_entry_t push_entry,
    output fetch_entry_t issue_entry,
    output logic         resp_uncache,
    output logic [CW-1:0] count,
    output logic [CW-1:0] pending
);
    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, iss_ptr, rsp_ptr;

    function automatic logic [PW-1:0] next(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= push_entry;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr  <= '0;
            iss_ptr <= '0;
            rsp_ptr <= '0;
            count   <= '0;
            pending <= '0;
        end else begin
            if (push) wr_ptr <= next(wr_ptr);
            if (issue) iss_ptr <= next(iss_ptr);
            if (pop) rsp_ptr <= next(rsp_ptr);
            count   <= count + CW'(push) - CW'(pop);
            pending <= pending + CW'(push) - CW'(issue);
        end

    assign issue_entry = mem[iss_ptr];
    // During a pop cycle the head being answered is already the next entry.
    assign resp_uncache = mem[pop ? next(rsp_ptr) : rsp_ptr].uncache;
endmodule

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: answers in-order instruction-fetch requests with one AXI read
// each, returning a 64-bit instruction pair and a one-cycle data_ok in request order.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                inst_sram_req_i,
    input  logic [31:0]                         inst_sram_addr_i,
    input  logic                                inst_sram_uncache_i,
    output logic                                inst_sram_addr_ok_o,
    output logic                                inst_sram_data_ok_o,
    output logic [FETCH_WIDTH-1:0]              inst_sram_rdata_o,
    output logic [CacheDisposeInstNumWidth-1:0] cache_dispose_inst_num_o,
    output logic                                resp_err_o,
    output logic [3:0]                          arid_o,
    output logic [31:0]                         araddr_o,
    output logic [7:0]                          arlen_o,
    output logic [2:0]                          arsize_o,
    output logic [1:0]                          arburst_o,
    output logic                                arvalid_o,
    input  logic                                arready_i,
    input  logic [31:0]                         rdata_i,
    input  logic [1:0]                          rresp_i,
    input  logic                                rlast_i,
    input  logic                                rvalid_i,
    output logic                                rready_o
);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [CW-1:0] count, pending, issued;
    fetch_entry_t  new_entry, issue_entry, ar_src;
    logic          accept, issue, beat, resp_uncache, unused;
    ar_state_t     ar_state;
    r_state_t      r_state;
    logic [31:0]   lo_q;

    // A full queue may still accept in a data_ok cycle because the pop frees a slot.
    assign accept = inst_sram_req_i & ~rst & (count < CW'(QDEPTH) | inst_sram_data_ok_o);
    assign inst_sram_addr_ok_o = accept;
    assign new_entry = '{line: inst_sram_addr_i[31:3], uncache: inst_sram_uncache_i};
    assign unused = ^inst_sram_addr_i[2:0];
    assign issue = arvalid_o & arready_i;
    assign issued = count - pending - CW'(inst_sram_data_ok_o);
    assign rready_o = issued != '0;
    assign beat = rvalid_i & rready_o;
    assign ar_src = pending != '0 ? issue_entry : new_entry;
    assign cache_dispose_inst_num_o = CacheDisposeInstNumWidth'(count);
    assign arid_o = AXI_ID;
    assign arburst_o = BURST_INCR;

    fetch_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (accept),
        .issue        (issue),
        .pop          (inst_sram_data_ok_o),
        .push_entry   (new_entry),
        .issue_entry  (issue_entry),
        .resp_uncache (resp_uncache),
        .count        (count),
        .pending      (pending)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ar_state  <= AR_IDLE;
            arvalid_o <= 1'b0;
            araddr_o  <= '0;
            arlen_o   <= '0;
            arsize_o  <= '0;
        end else if (ar_state == AR_IDLE) begin
            if (pending != '0 || accept) begin
                ar_state  <= AR_SEND;
                arvalid_o <= 1'b1;
                araddr_o  <= {ar_src.line, 3'b000};
                arlen_o   <= burst_len(ar_src.uncache);
                arsize_o  <= SIZE_4B;
            end
        end else if (arready_i) begin
            ar_state  <= AR_IDLE;
            arvalid_o <= 1'b0;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state             <= R_LO;
            lo_q                <= '0;
            inst_sram_data_ok_o <= 1'b0;
            inst_sram_rdata_o   <= '0;
            resp_err_o          <= 1'b0;
        end else begin
            inst_sram_data_ok_o <= beat & (r_state == R_HI | rlast_i | resp_uncache);
            resp_err_o          <= rvalid_i & (~rready_o | rresp_i != 2'b00);
            if (beat && r_state == R_HI) begin
                inst_sram_rdata_o <= {rdata_i, lo_q};
                r_state           <= R_LO;
            end else if (beat && (rlast_i || resp_uncache)) begin
                inst_sram_rdata_o <= {32'd0, rdata_i};
            end else if (beat) begin
                lo_q    <= rdata_i;
                r_state <= R_HI;
            end
        end
endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb_inst_fetch_responder: scoreboard bench with an in-order AXI read slave model
// for the instruction-fetch responder.
module tb_inst_fetch_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_sram_req_i = 1'b0;
    logic [31:0] inst_sram_addr_i = '0;
    logic        inst_sram_uncache_i = 1'b0;
    logic        inst_sram_addr_ok_o, inst_sram_data_ok_o, resp_err_o, arvalid_o, rready_o;
    logic [63:0] inst_sram_rdata_o;
    logic [1:0]  cache_dispose_inst_num_o, arburst_o;
    logic [3:0]  arid_o;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic        arready_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0;
    logic        rlast_i = 1'b0;
    logic        rvalid_i = 1'b0;

    inst_fetch_responder dut (
        .clk                      (clk),
        .rst                      (rst),
        .inst_sram_req_i          (inst_sram_req_i),
        .inst_sram_addr_i         (inst_sram_addr_i),
        .inst_sram_uncache_i      (inst_sram_uncache_i),
        .inst_sram_addr_ok_o      (inst_sram_addr_ok_o),
        .inst_sram_data_ok_o      (inst_sram_data_ok_o),
        .inst_sram_rdata_o        (inst_sram_rdata_o),
        .cache_dispose_inst_num_o (cache_dispose_inst_num_o),
        .resp_err_o               (resp_err_o),
        .arid_o                   (arid_o),
        .araddr_o                 (araddr_o),
        .arlen_o                  (arlen_o),
        .arsize_o                 (arsize_o),
        .arburst_o                (arburst_o),
        .arvalid_o                (arvalid_o),
        .arready_i                (arready_i),
        .rdata_i                  (rdata_i),
        .rresp_i                  (rresp_i),
        .rlast_i                  (rlast_i),
        .rvalid_i                 (rvalid_i),
        .rready_o                 (rready_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    int          n_vec = 0, n_miss = 0, cyc = 0;
    int          ok_cnt = 0, err_cnt = 0, last_ok_cyc = 0;
    int          beats_done = 0, err_at = -1, stray_req_n = 0, stray_done_n = 0;
    bit          gaps = 0, ar_rand = 0, ar_set = 1;
    logic [63:0] sb[$];
    ar_t         arq[$];

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial forever begin
        @(posedge clk);
        #2;
        arready_i = ar_rand ? 1'($urandom_range(0, 1)) : ar_set;
    end
    initial begin
        #200us;
        $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h1c00_0000: return 32'h1111_1111;
            32'h1c00_0004: return 32'h2222_2222;
            32'hbfc0_0000: return 32'hdead_beef;
            default:       return a ^ 32'h5a5a_c3c3;
        endcase
    endfunction

    function automatic logic [63:0] exp_of(input logic [31:0] a, input logic u);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        return {u ? 32'd0 : mem_fn(b + 32'd4), mem_fn(b)};
    endfunction

    // AXI read slave: decides on the handshakes seen at negedge, updates after posedge.
    initial begin
        bit          ar_hs, r_hs, in_rst, stray_on;
        logic [31:0] ar_a;
        logic [7:0]  ar_l;
        int          beat;
        stray_on = 0;
        beat = 0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid_o & arready_i;
            r_hs = rvalid_i & rready_o;
            ar_a = araddr_o;
            ar_l = arlen_o;
            in_rst = rst;
            @(posedge clk);
            #1;
            if (in_rst) begin
                arq.delete();
                beat = 0;
                stray_on = 0;
                rvalid_i = 0;
                rlast_i = 0;
            end else begin
                if (ar_hs) arq.push_back('{ar_a, ar_l});
                if (r_hs) begin
                    beats_done++;
                    if (rlast_i) begin
                        void'(arq.pop_front());
                        beat = 0;
                    end else beat++;
                end
                if (stray_on) begin
                    stray_on = 0;
                    rvalid_i = 0;
                end
                if (!(rvalid_i && !r_hs)) begin
                    if (stray_req_n != stray_done_n && arq.size() == 0) begin
                        stray_on = 1;
                        stray_done_n++;
                        rvalid_i = 1;
                        rdata_i = 32'hbad0_bad0;
                        rlast_i = 1;
                        rresp_i = 2'b00;
                    end else if (arq.size() > 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
                        rvalid_i = 1;
                        rdata_i = mem_fn(arq[0].addr + 32'(4 * beat));
                        rlast_i = (beat == int'(arq[0].len));
                        rresp_i = (beats_done == err_at) ? 2'b10 : 2'b00;
                    end else begin
                        rvalid_i = 0;
                        rlast_i = 0;
                    end
                end
            end
        end
    end

    // Output monitor: data_ok against scoreboard, error pulses, AR stability.
    initial begin
        bit          prev_stall;
        logic [31:0] prev_addr;
        logic [7:0]  prev_len;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (inst_sram_data_ok_o) begin
                    ok_cnt++;
                    last_ok_cyc = cyc;
                    if (sb.size() == 0) check("unexpected_data_ok", 64'(inst_sram_data_ok_o), 64'd0);
                    else check("rdata", inst_sram_rdata_o, sb.pop_front());
                end
                if (resp_err_o) err_cnt++;
                if (prev_stall) begin
                    check("ar_hold_valid", 64'(arvalid_o), 64'd1);
                    check("ar_hold_addr", 64'(araddr_o), 64'(prev_addr));
                    check("ar_hold_len", 64'(arlen_o), 64'(prev_len));
                end
            end
            prev_stall = arvalid_o & !arready_i & !rst;
            prev_addr = araddr_o;
            prev_len = arlen_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic u, output int acc_cyc);
        inst_sram_req_i = 1;
        inst_sram_addr_i = a;
        inst_sram_uncache_i = u;
        acc_cyc = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (inst_sram_addr_ok_o) begin
                sb.push_back(exp_of(a, u));
                acc_cyc = cyc;
                step();
                inst_sram_req_i = 0;
                return;
            end
            step();
        end
        check("accept_timeout", 64'd0, 64'd1);
        inst_sram_req_i = 0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && sb.size() != 0; i++) step();
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int t0, e0, o0;
        bit got;
        #1 rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_ok", 64'(inst_sram_data_ok_o), 64'd0);
        check("rst_arvalid", 64'(arvalid_o), 64'd0);
        check("rst_rready", 64'(rready_o), 64'd0);
        check("rst_dispose", 64'(cache_dispose_inst_num_o), 64'd0);
        check("rst_arburst", 64'(arburst_o), 64'd1);
        check("rst_arid", 64'(arid_o), 64'd0);
        step();
        rst = 0;
        step();
        step();

        fetch(32'h1c00_0004, 1'b0, t0);
        @(negedge clk);
        check("cached_arvalid", 64'(arvalid_o), 64'd1);
        check("cached_araddr", 64'(araddr_o), 64'h1c00_0000);
        check("cached_arlen", 64'(arlen_o), 64'd1);
        check("cached_arsize", 64'(arsize_o), 64'd2);
        check("cached_dispose", 64'(cache_dispose_inst_num_o), 64'd1);
        step();
        wait_drain();
        check("cached_latency", 64'(last_ok_cyc - t0), 64'd4);
        @(negedge clk);
        check("cached_dispose_after", 64'(cache_dispose_inst_num_o), 64'd0);
        step();

        fetch(32'hbfc0_0000, 1'b1, t0);
        @(negedge clk);
        check("uncached_arlen", 64'(arlen_o), 64'd0);
        check("uncached_araddr", 64'(araddr_o), 64'hbfc0_0000);
        step();
        wait_drain();
        check("uncached_latency", 64'(last_ok_cyc - t0), 64'd3);
        step();

        ar_set = 0;
        inst_sram_req_i = 1;
        inst_sram_addr_i = 32'h0000_0100;
        inst_sram_uncache_i = 0;
        @(negedge clk);
        check("full_addr_ok_a", 64'(inst_sram_addr_ok_o), 64'd1);
        sb.push_back(exp_of(inst_sram_addr_i, 1'b0));
        step();
        inst_sram_addr_i = 32'h0000_0208;
        @(negedge clk);
        check("full_addr_ok_b", 64'(inst_sram_addr_ok_o), 64'd1);
        sb.push_back(exp_of(inst_sram_addr_i, 1'b0));
        step();
        inst_sram_addr_i = 32'h0000_0304;
        inst_sram_uncache_i = 1;
        @(negedge clk);
        check("full_addr_ok_c", 64'(inst_sram_addr_ok_o), 64'd0);
        check("full_dispose", 64'(cache_dispose_inst_num_o), 64'd2);
        repeat (3) step();
        @(negedge clk);
        check("full_still_blocked", 64'(inst_sram_addr_ok_o), 64'd0);
        step();
        ar_set = 1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (inst_sram_addr_ok_o) begin
                got = 1;
                check("full_accept_in_ok_cycle", 64'(inst_sram_data_ok_o), 64'd1);
                sb.push_back(exp_of(inst_sram_addr_i, 1'b1));
            end
            step();
        end
        inst_sram_req_i = 0;
        inst_sram_uncache_i = 0;
        check("full_third_accepted", 64'(got), 64'd1);
        wait_drain();

        gaps = 1;
        ar_rand = 1;
        for (int i = 0; i < 8; i++) fetch($urandom(), 1'($urandom_range(0, 1)), t0);
        wait_drain();
        gaps = 0;
        ar_rand = 0;
        step();

        e0 = err_cnt;
        err_at = beats_done;
        fetch(32'h0000_1000, 1'b0, t0);
        wait_drain();
        repeat (2) step();
        check("rresp_err_pulses", 64'(err_cnt - e0), 64'd1);
        err_at = -1;

        e0 = err_cnt;
        o0 = ok_cnt;
        stray_req_n++;
        repeat (6) step();
        check("stray_err_pulses", 64'(err_cnt - e0), 64'd1);
        check("stray_no_data_ok", 64'(ok_cnt - o0), 64'd0);

        fetch(32'h2000_0010, 1'b0, t0);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = rvalid_i & rready_o & !rlast_i;
            step();
        end
        check("rst_first_beat_seen", 64'(got), 64'd1);
        rst = 1;
        @(negedge clk);
        check("midrst_data_ok", 64'(inst_sram_data_ok_o), 64'd0);
        check("midrst_rdata", inst_sram_rdata_o, 64'd0);
        check("midrst_arvalid", 64'(arvalid_o), 64'd0);
        check("midrst_araddr", 64'(araddr_o), 64'd0);
        check("midrst_rready", 64'(rready_o), 64'd0);
        check("midrst_dispose", 64'(cache_dispose_inst_num_o), 64'd0);
        check("midrst_resp_err", 64'(resp_err_o), 64'd0);
        sb.delete();
        step();
        step();
        rst = 0;
        step();
        step();
        fetch(32'h1c00_0000, 1'b0, t0);
        wait_drain();
        check("post_rst_latency", 64'(last_ok_cyc - t0), 64'd4);

        repeat (4) step();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/inst_fetch_responder.md
# inst_fetch_responder

Responder end of the CPU instruction-fetch request/data_ok interface. Accepts in-order fetch requests from pre-IF, issues one AXI read per request and returns a 64-bit instruction pair with a one-cycle `data_ok` pulse in request order. Reports the number of accepted-but-unanswered requests so the ID stage can cross-check its own count of pending and cancelled `data_ok`. The block never drops an accepted request: cancellation is handled entirely by the consumer.

## Interface
Parameters:
- `QDEPTH`, 2, maximum accepted-but-unanswered requests; `cache_dispose_inst_num_o` is sized for it.
- `AXI_ID`, 4'd0, fixed `arid`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `inst_sram_req_i`  in  1  fetch request.
- `inst_sram_addr_i`  in  32  fetch address; bits [2:0] are ignored.
- `inst_sram_uncache_i`  in  1  uncached fetch; only the low word is returned.
- `inst_sram_addr_ok_o`  out  1  request accepted this cycle.
- `inst_sram_data_ok_o`  out  1  one-cycle pulse; oldest request's data is valid.
- `inst_sram_rdata_o`  out  64  {inst at addr+4, inst at addr}.
- `cache_dispose_inst_num_o`  out  2  accepted requests without `data_ok` yet.
- `resp_err_o`  out  1  one-cycle pulse on `rresp`≠0 or an unexpected R beat.
- `arid_o`  out  4  read address ID.
- `araddr_o`  out  32  read address.
- `arlen_o`  out  8  burst length.
- `arsize_o`  out  3  beat size.
- `arburst_o`  out  2  burst type.
- `arvalid_o`  out  1  read address valid.
- `arready_i`  in  1  read address ready.
- `rdata_i`  in  32  read data.
- `rresp_i`  in  2  read response.
- `rlast_i`  in  1  last beat.
- `rvalid_i`  in  1  read data valid.
- `rready_o`  out  1  read data ready.

## Operation
- **Request queue.** QDEPTH-entry FIFO of {addr[31:3], uncache}, with write pointer, AR-issue pointer, response pointer and count.
- **Accept.** `addr_ok` = `req` & (count < QDEPTH), combinational. On accept, push the entry and increment count.
- **Retire.** The cycle `data_ok_o` is high: pop the entry and decrement count. Push and pop in the same cycle leave count unchanged.
- **Dispose count.** `cache_dispose_inst_num_o` = count.
- **AR FSM.**
  - AR_IDLE → AR_SEND when an accepted entry has not yet been issued.
  - AR_SEND → AR_IDLE on `arready_i`, advancing the issue pointer.
  - `arvalid_o` is registered and high only in AR_SEND. `araddr_o` and `arlen_o` are held stable while `arvalid_o` is high.
  - Cached: `araddr`={addr[31:3],3'b000}, `arlen`=1, `arsize`=2, `arburst`=INCR.
  - Uncached: `arlen`=0, `araddr` as cached.
- **R FSM.**
  - R_LO: first beat goes to `lo_q`. If `rlast_i`, finish; otherwise go to R_HI.
  - R_HI: beat goes to `hi_q`, then finish.
  - Finish: register `data_ok_o`=1 with `rdata_o`={hi,lo}. For an uncached fetch, hi=32'd0.
  - `rready_o` = 1 whenever the issued-but-unanswered count is > 0.
- **Errors.**
  - `rresp_i`≠0: data is still returned normally and `resp_err_o` pulses.
  - `rvalid_i` with nothing issued: the beat is ignored and `resp_err_o` pulses.
- **Reset (any time).** Queue, pointers, count and FSMs clear; all outputs go to 0 (`arid_o`=AXI_ID, `arburst_o`=INCR). The AXI fabric is reset together with this block, so no in-flight beats survive.

## Timing
- Minimum latency, cached, with `arready`/`rvalid` immediate:
  - accept at cycle 0;
  - `arvalid` at cycle 1;
  - beats at cycles 2 and 3;
  - `data_ok` at cycle 4.
- Uncached minimum latency: `data_ok` at cycle 3.
- A second AR may issue while the first response is still returning; responses are in order (single ID).
- `data_ok_o` never lasts more than 1 cycle per request. Back-to-back `data_ok` pulses are allowed.
- Queue full (count=QDEPTH): `addr_ok`=0 until a `data_ok` cycle. In that cycle `addr_ok` may be 1, since pop and push coincide.

## Structure
- A shared package holds the AXI constants (BURST_INCR, SIZE_4B), the fetch-width macros (64-bit pair) and `CacheDisposeInstNumWidth`, sized to match the ID stage.
- One sub-module, `fetch_req_fifo`: the QDEPTH-entry queue with separate issue and response pointers and a count output.
- The AR and R FSMs live in the top module.

## Test plan
- **Single cached fetch.** Req addr 0x1c000004, immediate ready, beats 0x11111111 then 0x22222222 → `araddr`=0x1c000000, `arlen`=1, `data_ok` at cycle 4, `rdata`=0x22222222_11111111, dispose count goes 1→0.
- **Uncached fetch.** Req 0xbfc00000 with uncache=1, beat 0xdeadbeef → `arlen`=0, `rdata`=0x00000000_deadbeef, `data_ok` at cycle 3.
- **Queue full.** Three consecutive reqs while `arready`=0 → `addr_ok` 1,1,0 and dispose count=2. Releasing `arready` gives two in-order `data_ok` pulses, and the third req is accepted in the first `data_ok` cycle.
- **Stalled R.** Random `rvalid` gaps between beats → data is assembled correctly, and `arvalid`/`araddr` stay stable under `arready`=0.
- **Errors.** `rresp`=2'b10 → data returned and `resp_err_o` pulses once. A stray `rvalid` with count 0 → `resp_err_o` pulses and no `data_ok`.
- **Reset mid-burst.** Assert `rst` after the first beat → all outputs are 0 next cycle, count=0, and a fresh request afterwards completes normally.
